// File: rtl/sd_pkg.sv
// sd_pkg: constants and types shared by the SD-card read path.
//   SD_BLOCK_BYTES  payload bytes per single-block read
//   state_t         block loader sequencing states
//   err_code_t      loader error cause codes (value visible on err_code)
//   sd_block_addr   maps a block number to the SD command address
package sd_pkg;

    localparam int unsigned SD_BLOCK_BYTES = 512;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_ACK,
        RECV,
        DRAIN,
        DONE,
        ERR
    } state_t;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'd0,
        ERR_TIMEOUT = 2'd1,
        ERR_SHORT   = 2'd2,
        ERR_OVERRUN = 2'd3
    } err_code_t;

    // SDHC cards take a block number; SDSC cards take a byte address.
    function automatic logic [31:0] sd_block_addr(input logic [31:0] lba, input logic byte_mode);
        return byte_mode ? {lba[22:0], 9'd0} : lba;
    endfunction

endpackage

// File: rtl/sd_timeout_ctr.sv
// sd_timeout_ctr: saturating cycle counter for SD transaction watchdogs.
//   clock, reset  system clock, synchronous active-high reset
//   clear         restart counting from zero
//   enable        count one cycle
//   expired       high once TIMEOUT_CYCLES-1 counted cycles have elapsed
module sd_timeout_ctr #(
    parameter int unsigned TIMEOUT_CYCLES = 2000000,
    parameter int unsigned TO_W           = 21
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    logic [TO_W-1:0] count;

    assign expired = (count == TO_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            count <= '0;
        end else if (enable && !expired) begin
            count <= count + TO_W'(1);
        end
    end

endmodule

// File: rtl/sd_block_loader.sv
// sd_block_loader: loads a run of 512-byte SD blocks into on-chip memory.
//   clock, reset                  system clock, synchronous active-high reset
//   start, start_lba, num_blocks, dest_base
//                                 load command, sampled only when idle
//   busy, done, err, err_code     status: busy while loading, done pulse,
//                                 sticky error with cause
//   sd_idle, sd_byte_valid, sd_byte
//                                 SD read engine status and byte stream
//   sd_begin_read, sd_addr        single-block read request to the engine
//   wr_en, wr_addr, wr_data       byte write port into memory
module sd_block_loader
    import sd_pkg::*;
#(
    parameter int unsigned MEM_AW          = 16,
    parameter int unsigned BYTE_ADDRESSING = 0,
    parameter int unsigned TIMEOUT_CYCLES  = 2000000,
    parameter int unsigned TO_W            = 21
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [31:0]       start_lba,
    input  logic [15:0]       num_blocks,
    input  logic [MEM_AW-1:0] dest_base,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [1:0]        err_code,
    input  logic              sd_idle,
    input  logic              sd_byte_valid,
    input  logic [7:0]        sd_byte,
    output logic              sd_begin_read,
    output logic [31:0]       sd_addr,
    output logic              wr_en,
    output logic [MEM_AW-1:0] wr_addr,
    output logic [7:0]        wr_data
);

    state_t            state, next_state;
    err_code_t         next_code;
    logic [31:0]       lba;
    logic [15:0]       blocks_left;
    logic [MEM_AW-1:0] waddr;
    logic [9:0]        byte_cnt;
    logic              accept, issue_fire, write_byte, block_done;
    logic              to_expired;

    sd_timeout_ctr #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
        .TO_W          (TO_W)
    ) u_timeout (
        .clock  (clock),
        .reset  (reset),
        .clear  (state == ISSUE),
        .enable (state == WAIT_ACK || state == RECV || state == DRAIN),
        .expired(to_expired)
    );

    assign busy = (state == ISSUE) || (state == WAIT_ACK) || (state == RECV) || (state == DRAIN);

    always_comb begin
        next_state = state;
        next_code  = ERR_NONE;
        accept     = 1'b0;
        issue_fire = 1'b0;
        write_byte = 1'b0;
        block_done = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept     = 1'b1;
                    next_state = (num_blocks == '0) ? DONE : ISSUE;
                end
            end
            ISSUE: begin
                // Waiting for idle also drains a block left running by a reset.
                if (sd_idle) begin
                    issue_fire = 1'b1;
                    next_state = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                if (to_expired) begin
                    next_state = ERR;
                    next_code  = ERR_TIMEOUT;
                end else if (!sd_idle) begin
                    next_state = RECV;
                end
            end
            RECV: begin
                // Leave on the 512th byte itself so byte_cnt never needs a
                // separate "full" cycle in RECV.
                if (to_expired) begin
                    next_state = ERR;
                    next_code  = ERR_TIMEOUT;
                end else if (sd_byte_valid) begin
                    write_byte = 1'b1;
                    if (byte_cnt == 10'(SD_BLOCK_BYTES - 1)) begin
                        next_state = DRAIN;
                    end else if (sd_idle) begin
                        next_state = ERR;
                        next_code  = ERR_SHORT;
                    end
                end else if (sd_idle) begin
                    next_state = ERR;
                    next_code  = ERR_SHORT;
                end
            end
            DRAIN: begin
                if (to_expired) begin
                    next_state = ERR;
                    next_code  = ERR_TIMEOUT;
                end else if (sd_byte_valid) begin
                    next_state = ERR;
                    next_code  = ERR_OVERRUN;
                end else if (sd_idle) begin
                    block_done = 1'b1;
                    next_state = (blocks_left == 16'd1) ? DONE : ISSUE;
                end
            end
            DONE:    next_state = IDLE;
            ERR:     next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= IDLE;
            lba           <= '0;
            blocks_left   <= '0;
            waddr         <= '0;
            byte_cnt      <= '0;
            done          <= 1'b0;
            err           <= 1'b0;
            err_code      <= '0;
            sd_begin_read <= 1'b0;
            sd_addr       <= '0;
            wr_en         <= 1'b0;
            wr_addr       <= '0;
            wr_data       <= '0;
        end else begin
            state         <= next_state;
            sd_begin_read <= issue_fire;
            wr_en         <= write_byte;
            done          <= (state == DONE);
            if (accept) begin
                lba         <= start_lba;
                blocks_left <= num_blocks;
                waddr       <= dest_base;
                err         <= 1'b0;
                err_code    <= '0;
            end
            if (issue_fire) begin
                sd_addr  <= sd_block_addr(lba, BYTE_ADDRESSING != 0);
                byte_cnt <= '0;
            end
            if (write_byte) begin
                wr_addr  <= waddr;
                wr_data  <= sd_byte;
                waddr    <= waddr + MEM_AW'(1);
                byte_cnt <= byte_cnt + 10'd1;
            end
            if (block_done) begin
                blocks_left <= blocks_left - 16'd1;
                lba         <= lba + 32'd1;
            end
            if (next_state == ERR && state != ERR) begin
                err      <= 1'b1;
                err_code <= next_code;
            end
        end
    end

endmodule

// File: tb/tb_sd_block_loader.sv
// tb_sd_block_loader: directed bench for sd_block_loader.
// Two instances share all inputs: one with block addressing, one with byte
// addressing. The SD engine is modelled inline by the scenario tasks.
module tb_sd_block_loader;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [31:0] start_lba = '0;
    logic [15:0] num_blocks = '0;
    logic [15:0] dest_base = '0;
    logic        sd_idle = 1'b1;
    logic        sd_byte_valid = 1'b0;
    logic [7:0]  sd_byte = '0;

    logic        busy_a, done_a, err_a, sd_begin_read_a, wr_en_a;
    logic [1:0]  err_code_a;
    logic [31:0] sd_addr_a;
    logic [15:0] wr_addr_a;
    logic [7:0]  wr_data_a;
    logic        busy_b, done_b, err_b, sd_begin_read_b, wr_en_b;
    logic [1:0]  err_code_b;
    logic [31:0] sd_addr_b;
    logic [15:0] wr_addr_b;
    logic [7:0]  wr_data_b;

    int checks = 0;
    int failures = 0;

    int          br_cnt = 0;
    int          wr_cnt = 0;
    int          done_cnt = 0;
    logic [31:0] addr_log_a[$];
    logic [31:0] addr_log_b[$];
    logic [15:0] wa_q[$];
    logic [7:0]  wd_q[$];

    always #5 clock = ~clock;

    sd_block_loader #(
        .MEM_AW(16), .BYTE_ADDRESSING(0), .TIMEOUT_CYCLES(1000), .TO_W(10)
    ) dut_a (
        .clock(clock), .reset(reset), .start(start), .start_lba(start_lba),
        .num_blocks(num_blocks), .dest_base(dest_base), .busy(busy_a),
        .done(done_a), .err(err_a), .err_code(err_code_a), .sd_idle(sd_idle),
        .sd_byte_valid(sd_byte_valid), .sd_byte(sd_byte),
        .sd_begin_read(sd_begin_read_a), .sd_addr(sd_addr_a),
        .wr_en(wr_en_a), .wr_addr(wr_addr_a), .wr_data(wr_data_a)
    );

    sd_block_loader #(
        .MEM_AW(16), .BYTE_ADDRESSING(1), .TIMEOUT_CYCLES(1000), .TO_W(10)
    ) dut_b (
        .clock(clock), .reset(reset), .start(start), .start_lba(start_lba),
        .num_blocks(num_blocks), .dest_base(dest_base), .busy(busy_b),
        .done(done_b), .err(err_b), .err_code(err_code_b), .sd_idle(sd_idle),
        .sd_byte_valid(sd_byte_valid), .sd_byte(sd_byte),
        .sd_begin_read(sd_begin_read_b), .sd_addr(sd_addr_b),
        .wr_en(wr_en_b), .wr_addr(wr_addr_b), .wr_data(wr_data_b)
    );

    // Outputs are sampled on the falling edge, away from the active edge.
    always @(negedge clock) begin
        if (sd_begin_read_a) begin
            br_cnt++;
            addr_log_a.push_back(sd_addr_a);
            addr_log_b.push_back(sd_addr_b);
        end
        if (wr_en_a) begin
            wr_cnt++;
            wa_q.push_back(wr_addr_a);
            wd_q.push_back(wr_data_a);
        end
        if (done_a) done_cnt++;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_logs();
        br_cnt = 0;
        wr_cnt = 0;
        done_cnt = 0;
        addr_log_a.delete();
        addr_log_b.delete();
        wa_q.delete();
        wd_q.delete();
    endtask

    task automatic issue_start(input logic [31:0] l, input logic [15:0] n, input logic [15:0] b);
        start_lba = l;
        num_blocks = n;
        dest_base = b;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Engine model for one block: waits for the read request, drops idle,
    // streams nbytes (pattern i + 37*k) with a gap every 7th byte, then idles.
    // waits = polls until the request was seen, -1 if it never came.
    task automatic serve_block(input int nbytes, input int k, output int waits);
        waits = -1;
        for (int t = 1; t <= 100 && waits < 0; t++) begin
            tick();
            if (sd_begin_read_a) waits = t;
        end
        if (waits < 0) return;
        sd_idle = 1'b0;
        tick();
        for (int i = 0; i < nbytes; i++) begin
            sd_byte_valid = 1'b1;
            sd_byte = 8'(i + 37 * k);
            tick();
            if (i % 7 == 6) begin
                sd_byte_valid = 1'b0;
                tick();
            end
        end
        sd_byte_valid = 1'b0;
        sd_idle = 1'b1;
        tick();
    endtask

    function automatic int count_bad(input logic [15:0] base, input int n, input int k0);
        int bad = 0;
        logic [15:0] ea;
        logic [7:0]  ed;
        for (int j = 0; j < n; j++) begin
            ea = 16'(base + j);
            ed = 8'((j % 512) + 37 * (k0 + j / 512));
            if (j >= wa_q.size() || wa_q[j] !== ea || wd_q[j] !== ed) bad++;
        end
        return bad;
    endfunction

    task automatic wait_done();
        for (int t = 0; t < 10 && done_cnt == 0; t++) tick();
        tick();
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        sd_idle = 1'b1;
        sd_byte_valid = 1'b0;
        tick();
        tick();
        checks++;
        if ({busy_a, done_a, err_a, sd_begin_read_a, wr_en_a} !== 5'b0) begin
            failures++;
            $display("FAIL reset_flags: got busy/done/err/begin/wr=%b expected 00000",
                     {busy_a, done_a, err_a, sd_begin_read_a, wr_en_a});
        end
        checks++;
        if (err_code_a !== 2'd0 || sd_addr_a !== 32'd0) begin
            failures++;
            $display("FAIL reset_code_addr: got err_code=%0d sd_addr=%h expected 0 0", err_code_a, sd_addr_a);
        end
        checks++;
        if (wr_addr_a !== 16'd0 || wr_data_a !== 8'd0) begin
            failures++;
            $display("FAIL reset_wr: got wr_addr=%h wr_data=%h expected 0 0", wr_addr_a, wr_data_a);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_single_block();
        int waits;
        clear_logs();
        issue_start(32'h10, 16'd1, 16'h0100);
        checks++;
        if (busy_a !== 1'b1) begin
            failures++;
            $display("FAIL single_busy: got %b expected 1", busy_a);
        end
        serve_block(512, 0, waits);
        // start sampled in cycle 0, request visible in cycle 2 => first poll
        checks++;
        if (waits != 1) begin
            failures++;
            $display("FAIL single_start_latency: got polls=%0d expected 1", waits);
        end
        wait_done();
        checks++;
        if (br_cnt != 1 || addr_log_a.size() != 1 || addr_log_a[0] !== 32'h10 || addr_log_b[0] !== 32'h2000) begin
            failures++;
            $display("FAIL single_sd_addr: got reads=%0d addr_a=%h addr_b=%h expected 1 00000010 00002000",
                     br_cnt, (addr_log_a.size() > 0) ? addr_log_a[0] : 32'hx,
                     (addr_log_b.size() > 0) ? addr_log_b[0] : 32'hx);
        end
        checks++;
        if (wr_cnt != 512 || count_bad(16'h0100, 512, 0) != 0 || wa_q[511] !== 16'h02FF) begin
            failures++;
            $display("FAIL single_writes: got count=%0d bad=%0d expected 512 0", wr_cnt, count_bad(16'h0100, 512, 0));
        end
        checks++;
        if (done_cnt != 1 || err_a !== 1'b0 || busy_a !== 1'b0) begin
            failures++;
            $display("FAIL single_status: got done_pulses=%0d err=%b busy=%b expected 1 0 0", done_cnt, err_a, busy_a);
        end
    endtask

    task automatic test_back_to_back();
        int waits;
        int missed = 0;
        clear_logs();
        issue_start(32'd5, 16'd3, 16'h1234);
        for (int k = 0; k < 3; k++) begin
            serve_block(512, k, waits);
            if (waits < 0) missed++;
        end
        checks++;
        if (missed != 0) begin
            failures++;
            $display("FAIL multi_requests_seen: got missing=%0d expected 0", missed);
        end
        wait_done();
        checks++;
        if (br_cnt != 3 || addr_log_b.size() != 3 || addr_log_b[0] !== 32'hA00 ||
            addr_log_b[1] !== 32'hC00 || addr_log_b[2] !== 32'hE00) begin
            failures++;
            $display("FAIL multi_byte_addr: got reads=%0d expected 3 at A00 C00 E00", br_cnt);
        end
        checks++;
        if (addr_log_a.size() != 3 || addr_log_a[0] !== 32'd5 || addr_log_a[1] !== 32'd6 || addr_log_a[2] !== 32'd7) begin
            failures++;
            $display("FAIL multi_block_addr: got %0d entries expected 5 6 7", addr_log_a.size());
        end
        checks++;
        if (wr_cnt != 1536 || count_bad(16'h1234, 1536, 0) != 0) begin
            failures++;
            $display("FAIL multi_writes: got count=%0d bad=%0d expected 1536 0", wr_cnt, count_bad(16'h1234, 1536, 0));
        end
        checks++;
        if (done_cnt != 1 || err_a !== 1'b0) begin
            failures++;
            $display("FAIL multi_done: got done_pulses=%0d err=%b expected 1 0", done_cnt, err_a);
        end
    endtask

    task automatic test_zero_blocks();
        clear_logs();
        issue_start(32'h99, 16'd0, 16'h0010);
        checks++;
        if (done_a !== 1'b0) begin
            failures++;
            $display("FAIL zero_done_cycle1: got %b expected 0", done_a);
        end
        tick();
        checks++;
        if (done_a !== 1'b1) begin
            failures++;
            $display("FAIL zero_done_cycle2: got %b expected 1", done_a);
        end
        for (int t = 0; t < 5; t++) tick();
        checks++;
        if (br_cnt != 0 || wr_cnt != 0 || done_cnt != 1) begin
            failures++;
            $display("FAIL zero_activity: got reads=%0d writes=%0d dones=%0d expected 0 0 1", br_cnt, wr_cnt, done_cnt);
        end
    endtask

    task automatic test_short_block();
        int waits;
        clear_logs();
        issue_start(32'h20, 16'd2, 16'h0400);
        serve_block(300, 0, waits);
        for (int t = 0; t < 10 && err_a !== 1'b1; t++) tick();
        checks++;
        if (err_a !== 1'b1 || err_code_a !== 2'd2 || busy_a !== 1'b0) begin
            failures++;
            $display("FAIL short_err: got err=%b code=%0d busy=%b expected 1 2 0", err_a, err_code_a, busy_a);
        end
        tick();
        checks++;
        if (wr_cnt != 300 || count_bad(16'h0400, 300, 0) != 0 || br_cnt != 1) begin
            failures++;
            $display("FAIL short_writes: got count=%0d reads=%0d expected 300 1", wr_cnt, br_cnt);
        end
        checks++;
        if (err_a !== 1'b1) begin
            failures++;
            $display("FAIL short_sticky: got err=%b expected 1", err_a);
        end
        issue_start(32'h0, 16'd0, 16'h0);
        checks++;
        if (err_a !== 1'b0 || err_code_a !== 2'd0) begin
            failures++;
            $display("FAIL short_clear: got err=%b code=%0d expected 0 0", err_a, err_code_a);
        end
        wait_done();
    endtask

    task automatic test_timeout();
        int waits = -1;
        int k = 0;
        clear_logs();
        sd_idle = 1'b1;
        issue_start(32'h30, 16'd1, 16'h0);
        for (int t = 1; t <= 20 && waits < 0; t++) begin
            tick();
            if (sd_begin_read_a) waits = t;
        end
        while (err_a !== 1'b1 && k < 1100) begin
            tick();
            k++;
        end
        checks++;
        if (waits < 0 || k > 1000 || k < 995) begin
            failures++;
            $display("FAIL timeout_latency: got %0d cycles after request expected 995..1000", k);
        end
        checks++;
        if (err_code_a !== 2'd1 || busy_a !== 1'b0 || wr_cnt != 0) begin
            failures++;
            $display("FAIL timeout_code: got code=%0d busy=%b writes=%0d expected 1 0 0", err_code_a, busy_a, wr_cnt);
        end
        tick();
    endtask

    task automatic test_reset_abort();
        int waits = -1;
        clear_logs();
        issue_start(32'h40, 16'd1, 16'h2000);
        for (int t = 1; t <= 20 && waits < 0; t++) begin
            tick();
            if (sd_begin_read_a) waits = t;
        end
        sd_idle = 1'b0;
        tick();
        for (int i = 0; i < 100; i++) begin
            sd_byte_valid = 1'b1;
            sd_byte = 8'(i);
            tick();
        end
        reset = 1'b1;
        tick();
        tick();
        checks++;
        if (busy_a !== 1'b0 || wr_en_a !== 1'b0 || sd_addr_a !== 32'd0) begin
            failures++;
            $display("FAIL abort_reset_state: got busy=%b wr_en=%b sd_addr=%h expected 0 0 0", busy_a, wr_en_a, sd_addr_a);
        end
        reset = 1'b0;
        tick();
        clear_logs();
        // Engine still streaming the stale block while the new command waits.
        issue_start(32'h50, 16'd1, 16'h3000);
        for (int i = 0; i < 30; i++) begin
            sd_byte_valid = ~sd_byte_valid;
            sd_byte = 8'hEE;
            tick();
        end
        checks++;
        if (br_cnt != 0 || wr_cnt != 0 || busy_a !== 1'b1) begin
            failures++;
            $display("FAIL abort_hold_off: got reads=%0d writes=%0d busy=%b expected 0 0 1", br_cnt, wr_cnt, busy_a);
        end
        sd_byte_valid = 1'b0;
        sd_idle = 1'b1;
        serve_block(512, 2, waits);
        wait_done();
        checks++;
        if (waits < 0 || br_cnt != 1 || addr_log_a[0] !== 32'h50) begin
            failures++;
            $display("FAIL abort_restart_read: got reads=%0d addr=%h expected 1 00000050",
                     br_cnt, (addr_log_a.size() > 0) ? addr_log_a[0] : 32'hx);
        end
        checks++;
        if (wr_cnt != 512 || count_bad(16'h3000, 512, 2) != 0 || done_cnt != 1) begin
            failures++;
            $display("FAIL abort_restart_writes: got count=%0d bad=%0d dones=%0d expected 512 0 1",
                     wr_cnt, count_bad(16'h3000, 512, 2), done_cnt);
        end
    endtask

    task automatic test_wrap();
        int waits;
        clear_logs();
        issue_start(32'h60, 16'd1, 16'hFF00);
        serve_block(512, 0, waits);
        wait_done();
        checks++;
        if (wr_cnt != 512 || wa_q[255] !== 16'hFFFF || wa_q[256] !== 16'h0000 || wa_q[511] !== 16'h00FF) begin
            failures++;
            $display("FAIL wrap_addr: got count=%0d expected FFFF->0000 ending at 00FF", wr_cnt);
        end
        checks++;
        if (count_bad(16'hFF00, 512, 0) != 0 || done_cnt != 1) begin
            failures++;
            $display("FAIL wrap_data: got bad=%0d dones=%0d expected 0 1", count_bad(16'hFF00, 512, 0), done_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_single_block();
        test_back_to_back();
        test_zero_blocks();
        test_short_block();
        test_timeout();
        test_reset_abort();
        test_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
